crc16_stream: RTL

CRC16_STREAM -- requirements
Module: crc16_stream

---
 rtl/crc16_pkg.sv | 6 +
 rtl/crc16_1021.sv | 16 +
 rtl/crc16_stream.sv | 60 ++++++
 3 files changed

// File: rtl/crc16_pkg.sv
// crc16_pkg: shared state encoding and constants for the CRC-16/0x1021 stream block
package crc16_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] LEN_MAX = 16'hFFFF;
endpackage

// File: rtl/crc16_1021.sv
// crc16_1021: one-byte MSB-first CRC-16 remainder update, polynomial 0x1021
module crc16_1021
  import crc16_pkg::*;
(
  input  logic [15:0] remainder,
  input  logic [7:0]  crc_input,
  output logic [15:0] crc_output
);
  logic [15:0] c;
  // shift the byte in bit by bit, folding the polynomial whenever the feedback bit is set
  always_comb begin
    c = remainder;
    for (int i = 7; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ crc_input[i]) ? CRC16_POLY : 16'h0000);
    crc_output = c;
  end
endmodule

// File: rtl/crc16_stream.sv
// crc16_stream: framed byte-stream CRC-16 (0x1021, MSB-first, no final XOR); CRC16_STREAM_CHECK_EN adds out_ok residue flag
module crc16_stream
  import crc16_pkg::*;
#(
  parameter logic [15:0] INIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_crc,
  output logic [15:0] out_len,
  output logic        busy
`ifdef CRC16_STREAM_CHECK_EN
  ,
  output logic        out_ok
`endif
);
  state_t state;
  logic [15:0] rem, rem_next, cnt, cnt_next;
  logic acc, hs;
  assign in_ready = state != DONE;
  assign busy = state != IDLE;
  assign acc = in_valid && in_ready;
  assign hs = out_valid && out_ready;
  assign cnt_next = cnt == LEN_MAX ? cnt : cnt + 16'd1;
  crc16_1021 u_step (.remainder(rem), .crc_input(in_data), .crc_output(rem_next));
`ifdef CRC16_STREAM_CHECK_EN
  assign out_ok = out_valid && out_crc == 16'h0000;
`endif
  // frame FSM: accumulate accepted bytes, present result in DONE until handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem <= INIT;
      cnt <= 16'h0000;
      out_valid <= 1'b0;
      out_crc <= 16'h0000;
      out_len <= 16'h0000;
    end else if (hs) begin
      state <= IDLE;
      out_valid <= 1'b0;
      rem <= INIT;
      cnt <= 16'h0000;
    end else if (acc) begin
      rem <= rem_next;
      cnt <= cnt_next;
      state <= in_last ? DONE : RUN;
      if (in_last) begin
        out_valid <= 1'b1;
        out_crc <= rem_next;
        out_len <= cnt_next;
      end
    end
  end
endmodule
